// File: rtl/mma_mem_arbiter.sv
// mma_mem_arbiter: grants the shared ICB port to one of five MMA data movers,
// using fixed priority with starvation aging and an output-FIFO-full override.
module mma_mem_arbiter #(
   parameter int SEL_WIDTH    = 3,
   parameter int STARVE_LIMIT = 64,
   parameter int CNT_WIDTH    = $clog2(STARVE_LIMIT + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 arb_en,
   input  logic                 fifo_full_flag,
   input  logic                 load_ia_req,
   input  logic                 load_weight_req,
   input  logic                 load_bias_req,
   input  logic                 load_quant_req,
   input  logic                 write_oa_req,
   output logic                 load_ia_granted,
   output logic                 load_weight_granted,
   output logic                 load_bias_granted,
   output logic                 load_quant_granted,
   output logic                 write_oa_granted,
   output logic [SEL_WIDTH-1:0] icb_sel,
   output logic                 arb_busy,
   output logic                 starve_flag
);
   localparam int N = 5;
   localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t               state_q, state_d;
   logic [N-1:0]         req, grant_q, grant_d;
   logic [SEL_WIDTH-1:0] sel_q, sel_d, win;
   logic                 busy_q, starve_q, starve_d;
   logic [CNT_WIDTH-1:0] cnt_q [N];
   logic [CNT_WIDTH-1:0] cnt_d [N];

   assign req = {write_oa_req, load_quant_req, load_bias_req, load_weight_req, load_ia_req};

   always_comb begin
      win = '0;
      for (int i = 0; i < N; i++) if (req[i]) win = SEL_WIDTH'(i);
      for (int i = 0; i < N; i++) if (req[i] && cnt_q[i] == LIMIT) win = SEL_WIDTH'(i);
      if (fifo_full_flag && write_oa_req) win = SEL_WIDTH'(4);
      state_d = state_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      if (state_q == IDLE) begin
         if (arb_en && |req) begin
            state_d = GRANT;
            grant_d = N'(1) << win;
            sel_d   = win;
         end
      end else if (~|(grant_q & req)) begin
         state_d = IDLE;
         grant_d = '0;
      end
      // a requester stops aging on the edge its grant is registered
      starve_d = 1'b0;
      for (int i = 0; i < N; i++) begin
         cnt_d[i] = (!req[i] || grant_d[i]) ? '0 :
                    (cnt_q[i] == LIMIT) ? cnt_q[i] : cnt_q[i] + 1'b1;
         starve_d = starve_d | (cnt_d[i] == LIMIT);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         sel_q    <= '0;
         busy_q   <= 1'b0;
         starve_q <= 1'b0;
         for (int i = 0; i < N; i++) cnt_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         sel_q    <= sel_d;
         busy_q   <= |grant_d;
         starve_q <= starve_d;
         for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign load_ia_granted     = grant_q[0];
   assign load_weight_granted = grant_q[1];
   assign load_bias_granted   = grant_q[2];
   assign load_quant_granted  = grant_q[3];
   assign write_oa_granted    = grant_q[4];
   assign icb_sel             = sel_q;
   assign arb_busy            = busy_q;
   assign starve_flag         = starve_q;
endmodule

// File: tb/tb_mma_mem_arbiter.sv
// tb_mma_mem_arbiter: directed and random stimulus against a cycle-level
// reference model; expected outputs go through a scoreboard queue.
module tb_mma_mem_arbiter;
   localparam int N = 5;
   localparam int LIM = 8;

   typedef struct {
      logic [4:0] g;
      logic [2:0] sel;
      logic       busy;
      logic       st;
   } exp_t;

   logic       clk = 1'b0, rst_n = 1'b0, arb_en = 1'b0, ff = 1'b0;
   logic [4:0] req = '0;
   logic       g0, g1, g2, g3, g4, arb_busy, starve_flag;
   logic [2:0] icb_sel;
   logic [4:0] gnt;

   exp_t sb[$];
   int   checks = 0, errors = 0;
   int   owner = -1, last = 0;
   int   waits[N];
   bit   auto_m[N], rearm[N];
   int   blen[N], held[N];

   assign gnt = {g4, g3, g2, g1, g0};

   mma_mem_arbiter #(.SEL_WIDTH(3), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .fifo_full_flag(ff),
      .load_ia_req(req[0]), .load_weight_req(req[1]), .load_bias_req(req[2]),
      .load_quant_req(req[3]), .write_oa_req(req[4]),
      .load_ia_granted(g0), .load_weight_granted(g1), .load_bias_granted(g2),
      .load_quant_granted(g3), .write_oa_granted(g4),
      .icb_sel(icb_sel), .arb_busy(arb_busy), .starve_flag(starve_flag)
   );

   always #5 clk = ~clk;

   function automatic int pick();
      if (ff && req[4]) return 4;
      for (int i = N - 1; i >= 0; i--) if (req[i] && waits[i] == LIM) return i;
      for (int i = N - 1; i >= 0; i--) if (req[i]) return i;
      return -1;
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      e.g    = (owner >= 0) ? 5'(1 << owner) : 5'd0;
      e.sel  = 3'(last);
      e.busy = owner >= 0;
      e.st   = 1'b0;
      for (int i = 0; i < N; i++) if (waits[i] == LIM) e.st = 1'b1;
      return e;
   endfunction

   task automatic model_reset();
      owner = -1;
      last  = 0;
      for (int i = 0; i < N; i++) waits[i] = 0;
   endtask

   // one clock: advance the model on the edge, queue its outputs, then let movers react
   task automatic tick();
      @(posedge clk);
      if (!rst_n) model_reset();
      else begin
         if (owner >= 0 && !req[owner]) owner = -1;
         else if (owner < 0 && arb_en && req != 0) begin
            owner = pick();
            last  = owner;
         end
         for (int i = 0; i < N; i++)
            waits[i] = (!req[i] || owner == i) ? 0 : (waits[i] < LIM ? waits[i] + 1 : LIM);
      end
      sb.push_back(model_out());
      #1;
      for (int i = 0; i < N; i++) if (auto_m[i]) begin
         if (owner == i) begin
            held[i]++;
            if (held[i] >= blen[i]) begin
               req[i]  = 1'b0;
               held[i] = 0;
            end
         end else if (!req[i] && rearm[i]) req[i] = 1'b1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("grant", 32'(gnt), 32'(e.g));
            chk("icb_sel", 32'(icb_sel), 32'(e.sel));
            chk("arb_busy", 32'(arb_busy), 32'(e.busy));
            chk("starve_flag", 32'(starve_flag), 32'(e.st));
            chk("onehot0", 32'($onehot0(gnt)), 32'd1);
         end
      end
   end

   initial begin
      model_reset();
      for (int i = 0; i < N; i++) begin
         auto_m[i] = 0; rearm[i] = 0; blen[i] = 4; held[i] = 0;
      end
      repeat (3) tick();
      rst_n  = 1'b1;
      arb_en = 1'b1;
      repeat (6) tick();
      // single IA burst
      req[0] = 1'b1;
      repeat (10) tick();
      req[0] = 1'b0;
      repeat (3) tick();
      // all five at once, one burst each
      for (int i = 0; i < N; i++) begin
         auto_m[i] = 1; rearm[i] = 0; blen[i] = 4; held[i] = 0;
      end
      req = '1;
      repeat (35) tick();
      for (int i = 0; i < N; i++) auto_m[i] = 0;
      req = '0;
      repeat (2) tick();
      // IA starves behind repeating weight/bias bursts
      req[0] = 1'b1;
      for (int i = 1; i <= 2; i++) begin
         auto_m[i] = 1; rearm[i] = 1; blen[i] = 8; held[i] = 0; req[i] = 1'b1;
      end
      repeat (40) tick();
      req[0] = 1'b0;
      repeat (30) tick();
      auto_m[1] = 0; auto_m[2] = 0; req = '0;
      repeat (3) tick();
      // fifo_full during a bias burst: no preemption, OA wins next
      req[2] = 1'b1;
      repeat (3) tick();
      ff = 1'b1; req[4] = 1'b1; req[3] = 1'b1;
      repeat (5) tick();
      req[2] = 1'b0;
      repeat (5) tick();
      req = '0; ff = 1'b0;
      repeat (3) tick();
      // arbitration disabled
      arb_en = 1'b0; req[1] = 1'b1;
      repeat (20) tick();
      arb_en = 1'b1;
      repeat (5) tick();
      req = '0;
      repeat (3) tick();
      // asynchronous reset in the middle of a quant burst
      req[3] = 1'b1; req[1] = 1'b1;
      repeat (4) tick();
      rst_n = 1'b0;
      void'(sb.pop_back());
      model_reset();
      sb.push_back(model_out());
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (6) tick();
      req = '0;
      repeat (3) tick();
      // random traffic
      for (int c = 0; c < 500; c++) begin
         for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
         arb_en = $urandom_range(0, 9) != 0;
         ff     = $urandom_range(0, 3) == 0;
         tick();
      end
      @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
